// File: rtl/spwm_pkg.sv
// Shared constants and types for the three-phase SPWM demodulator.
package spwm_pkg;

  localparam int CARRIER_W        = 8;
  localparam int WIN_LEN          = 256;
  localparam int MISMATCH_PERSIST = 4;
  localparam int STEP_LOCK        = 6;

  typedef logic [2:0] sector_t;

  localparam sector_t SEC_0   = 3'd0;
  localparam sector_t SEC_1   = 3'd1;
  localparam sector_t SEC_2   = 3'd2;
  localparam sector_t SEC_3   = 3'd3;
  localparam sector_t SEC_4   = 3'd4;
  localparam sector_t SEC_5   = 3'd5;
  localparam sector_t SEC_INV = 3'd7;

  typedef enum logic {
    ST_UNLOCK = 1'b0,
    ST_TRACK  = 1'b1
  } state_t;

  // Pattern is {s1,s2,s3}, each the MSB of that phase's duty.
  function automatic sector_t pattern_to_sector(input logic [2:0] pat);
    case (pat)
      3'b110:  return SEC_0;
      3'b100:  return SEC_1;
      3'b101:  return SEC_2;
      3'b001:  return SEC_3;
      3'b011:  return SEC_4;
      3'b010:  return SEC_5;
      default: return SEC_INV;
    endcase
  endfunction

  function automatic sector_t sector_inc(input sector_t s);
    return (s == SEC_5) ? SEC_0 : s + 3'd1;
  endfunction

  function automatic sector_t sector_dec(input sector_t s);
    return (s == SEC_0) ? SEC_5 : s - 3'd1;
  endfunction

endpackage

// File: rtl/spwm_duty_meter.sv
// One phase: 2-flop synchronizer, per-window high counter and saturating duty latch.
module spwm_duty_meter
  import spwm_pkg::*;
#(
  parameter int DATA_W = CARRIER_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] duty_o,
  output logic              sync_o
);

  logic [1:0]        sync_q;
  logic [DATA_W:0]   hi_q, hi_d, sum;
  logic [DATA_W-1:0] duty_q, duty_d;

  // A full window of ones yields 256, which does not fit the duty range.
  function automatic logic [DATA_W-1:0] sat_duty(input logic [DATA_W:0] v);
    return v[DATA_W] ? '1 : v[DATA_W-1:0];
  endfunction

  always_comb begin
    sum    = hi_q + {{DATA_W{1'b0}}, sync_q[1]};
    hi_d   = last_i ? '0 : sum;
    duty_d = last_i ? sat_duty(sum) : duty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hi_q   <= '0;
      duty_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_i};
      hi_q   <= hi_d;
      duty_q <= duty_d;
    end
  end

  assign duty_o = duty_q;
  assign sync_o = sync_q[1];

endmodule

// File: rtl/spwm_demod.sv
// Three-phase SPWM demodulator: duty per 256-clock window, sector and rotation tracking.
// Optional complement-mismatch check is built when SPWM_DEMOD_INV_CHECK_EN is defined.
module spwm_demod
  import spwm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_p1,
  input  logic                 in_p2,
  input  logic                 in_p3,
  input  logic                 in_p1_inv,
  input  logic                 in_p2_inv,
  input  logic                 in_p3_inv,
  output logic [CARRIER_W-1:0] duty_1,
  output logic [CARRIER_W-1:0] duty_2,
  output logic [CARRIER_W-1:0] duty_3,
  output logic                 duty_valid,
  output logic [2:0]           sector,
  output logic                 seq_fwd,
  output logic                 seq_lock,
  output logic                 inv_fault
);

  logic [CARRIER_W-1:0] win_q, win_d;
  logic                 last_win;
  logic                 vld_q;
  logic [2:0]           pwm_sync;

  assign last_win = (win_q == CARRIER_W'(WIN_LEN - 1));
  assign win_d    = win_q + CARRIER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      vld_q <= 1'b0;
    end else begin
      win_q <= win_d;
      vld_q <= last_win;
    end
  end

  spwm_duty_meter #(.DATA_W(CARRIER_W)) u_meter1 (
    .clk(clk), .rst(rst), .pwm_i(in_p1), .last_i(last_win), .duty_o(duty_1), .sync_o(pwm_sync[0])
  );
  spwm_duty_meter #(.DATA_W(CARRIER_W)) u_meter2 (
    .clk(clk), .rst(rst), .pwm_i(in_p2), .last_i(last_win), .duty_o(duty_2), .sync_o(pwm_sync[1])
  );
  spwm_duty_meter #(.DATA_W(CARRIER_W)) u_meter3 (
    .clk(clk), .rst(rst), .pwm_i(in_p3), .last_i(last_win), .duty_o(duty_3), .sync_o(pwm_sync[2])
  );

  state_t     state_q, state_d;
  sector_t    sec_q, sec_d, pat_sec;
  logic [2:0] step_q, step_d;
  logic       fwd_q, fwd_d;
  logic       is_fwd, is_rev;

  assign pat_sec = pattern_to_sector({duty_1[CARRIER_W-1], duty_2[CARRIER_W-1], duty_3[CARRIER_W-1]});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNLOCK;
      sec_q   <= SEC_INV;
      step_q  <= '0;
      fwd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      step_q  <= step_d;
      fwd_q   <= fwd_d;
    end
  end

  // Sector decisions are taken once per window, on the cycle duty_valid is high.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    step_d  = step_q;
    fwd_d   = fwd_q;
    is_fwd  = (pat_sec == sector_inc(sec_q));
    is_rev  = (pat_sec == sector_dec(sec_q));
    if (vld_q) begin
      case (state_q)
        ST_UNLOCK: begin
          sec_d = pat_sec;
          if (pat_sec != SEC_INV) begin
            state_d = ST_TRACK;
            step_d  = '0;
          end
        end
        ST_TRACK: begin
          if (pat_sec == SEC_INV) begin
            state_d = ST_UNLOCK;
            sec_d   = SEC_INV;
            step_d  = '0;
          end else if (is_fwd || is_rev) begin
            sec_d = pat_sec;
            if (is_fwd == fwd_q) begin
              step_d = (step_q == 3'(STEP_LOCK)) ? step_q : step_q + 3'd1;
            end else begin
              step_d = 3'd1;
              fwd_d  = is_fwd;
            end
          end else if (pat_sec != sec_q) begin
            state_d = ST_UNLOCK;
            sec_d   = pat_sec;
            step_d  = '0;
          end
        end
        default: state_d = ST_UNLOCK;
      endcase
    end
  end

  always_comb begin
    duty_valid = vld_q;
    sector     = sec_q;
    seq_fwd    = fwd_q;
    seq_lock   = (step_q == 3'(STEP_LOCK));
  end

`ifdef SPWM_DEMOD_INV_CHECK_EN
  logic [2:0]      inv_s0_q, inv_s1_q;
  logic [2:0]      eq;
  logic [2:0][2:0] mis_q, mis_d;
  logic            fault_q, fault_d;

  // Per-phase run length of "true equals complement", saturating at the trip count.
  always_comb begin
    eq      = pwm_sync ~^ inv_s1_q;
    mis_d   = mis_q;
    fault_d = fault_q;
    for (int i = 0; i < 3; i++) begin
      if (!eq[i]) mis_d[i] = '0;
      else if (mis_q[i] != 3'(MISMATCH_PERSIST)) mis_d[i] = mis_q[i] + 3'd1;
      if (mis_d[i] == 3'(MISMATCH_PERSIST)) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_s0_q <= '0;
      inv_s1_q <= '0;
      mis_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      inv_s0_q <= {in_p3_inv, in_p2_inv, in_p1_inv};
      inv_s1_q <= inv_s0_q;
      mis_q    <= mis_d;
      fault_q  <= fault_d;
    end
  end

  assign inv_fault = fault_q;
`else
  logic unused_inv;
  assign unused_inv = ^{in_p1_inv, in_p2_inv, in_p3_inv, pwm_sync};
  assign inv_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_spwm_demod.sv
// Randomized bench for spwm_demod against a window/sector reference model.
module tb_spwm_demod;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_p1, in_p2, in_p3;
  logic       in_p1_inv, in_p2_inv, in_p3_inv;
  logic [7:0] duty_1, duty_2, duty_3;
  logic       duty_valid;
  logic [2:0] sector;
  logic       seq_fwd, seq_lock, inv_fault;

  always #5 clk = ~clk;

  spwm_demod dut (
    .clk(clk), .rst(rst),
    .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3),
    .in_p1_inv(in_p1_inv), .in_p2_inv(in_p2_inv), .in_p3_inv(in_p3_inv),
    .duty_1(duty_1), .duty_2(duty_2), .duty_3(duty_3), .duty_valid(duty_valid),
    .sector(sector), .seq_fwd(seq_fwd), .seq_lock(seq_lock), .inv_fault(inv_fault)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stimulus: each phase is a 256-clock PWM with duty duty_set (256 = constant 1).
  int         duty_set[3];
  int         off_set[3];
  int         cyc    = 0;
  int         glitch = 0;
  logic [2:0] cur_bits;

  task automatic drive();
    logic [2:0] v;
    for (int k = 0; k < 3; k++) v[k] = (((cyc + off_set[k]) % 256) < duty_set[k]);
    in_p1 = v[0];
    in_p2 = v[1];
    in_p3 = v[2];
    if (glitch > 0) begin
      in_p1_inv = v[0];
      glitch--;
    end else begin
      in_p1_inv = ~v[0];
    end
    in_p2_inv = ~v[1];
    in_p3_inv = ~v[2];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Re-randomize only the phases whose sign bit changes, so boundary windows stay on-track.
  task automatic set_pat(input logic [2:0] bits, input bit force_all);
    for (int k = 0; k < 3; k++) begin
      if (force_all || bits[2-k] != cur_bits[2-k]) begin
        duty_set[k] = bits[2-k] ? int'($urandom_range(256, 160)) : int'($urandom_range(96, 0));
        off_set[k]  = int'($urandom_range(255, 0));
      end
    end
    cur_bits = bits;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!duty_valid && n <= 600);
    if (n > 600) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Reference model: input history since reset, windows of 256 synchronized samples.
  int         e = 0;
  int         hist[3][$];
  int         m_sec = 7, m_step = 0;
  bit         m_track = 0, m_fwd = 1, pend = 0;
  logic [2:0] m_pat;
  int         tbl[8] = '{7, 3, 5, 4, 1, 2, 0, 7};

  task automatic model_step(input int ns);
    int d;
    if (ns == 7) begin
      m_sec = 7; m_track = 0; m_step = 0;
    end else if (!m_track) begin
      m_sec = ns; m_track = 1; m_step = 0;
    end else begin
      d = (ns - m_sec + 6) % 6;
      if (d == 1 || d == 5) begin
        if ((d == 1) == m_fwd) m_step = (m_step >= 6) ? 6 : m_step + 1;
        else begin
          m_step = 1;
          m_fwd  = (d == 1);
        end
        m_sec = ns;
      end else if (d != 0) begin
        m_track = 0; m_step = 0; m_sec = ns;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      e = 0;
      for (int k = 0; k < 3; k++) hist[k].delete();
      m_sec = 7; m_step = 0; m_track = 0; m_fwd = 1; pend = 0;
    end else begin
      e++;
      hist[0].push_back(int'(in_p1));
      hist[1].push_back(int'(in_p2));
      hist[2].push_back(int'(in_p3));
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && e > 0) begin
      bit ev;
      int d[3];
      int cnt;
      ev = (e % 256 == 0);
      if (ev || duty_valid) chk("duty_valid", int'(duty_valid), int'(ev));
      if (ev) begin
        for (int k = 0; k < 3; k++) begin
          cnt = 0;
          for (int j = (e - 258 < 0) ? 0 : e - 258; j <= e - 3; j++) cnt += hist[k][j];
          d[k] = (cnt > 255) ? 255 : cnt;
        end
        chk("model_duty_1", int'(duty_1), d[0]);
        chk("model_duty_2", int'(duty_2), d[1]);
        chk("model_duty_3", int'(duty_3), d[2]);
        m_pat = {d[0] >= 128, d[1] >= 128, d[2] >= 128};
        pend  = 1;
      end else if (pend && e % 256 == 1) begin
        pend = 0;
        model_step(tbl[m_pat]);
        chk("model_sector", int'(sector), m_sec);
        chk("model_seq_fwd", int'(seq_fwd), int'(m_fwd));
        chk("model_seq_lock", int'(seq_lock), int'(m_step == 6));
      end
    end
  end

  logic [2:0] pats[7] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010, 3'b110};

  task automatic fwd_seq();
    set_pat(pats[0], 1'b1);
    pulse_rst();
    ticks(520);
    chk("seq_sector_0", int'(sector), 0);
    for (int i = 1; i < 7; i++) begin
      set_pat(pats[i], 1'b0);
      ticks(520);
      chk("seq_sector", int'(sector), i % 6);
      chk("seq_fwd", int'(seq_fwd), 1);
      chk("seq_lock", int'(seq_lock), int'(i == 6));
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_p1 = 0; in_p2 = 0; in_p3 = 0;
    in_p1_inv = 1; in_p2_inv = 1; in_p3_inv = 1;
    for (int k = 0; k < 3; k++) begin
      duty_set[k] = 0;
      off_set[k]  = 0;
    end
    cur_bits = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty_1", int'(duty_1), 0);
    chk("rst_duty_2", int'(duty_2), 0);
    chk("rst_duty_3", int'(duty_3), 0);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_sector", int'(sector), 7);
    chk("rst_seq_fwd", int'(seq_fwd), 1);
    chk("rst_seq_lock", int'(seq_lock), 0);
    chk("rst_inv_fault", int'(inv_fault), 0);
    tick();
    rst = 1'b0;

    // Duty 64 at random phase on p1, constant 1 on p2, constant 0 on p3.
    duty_set[0] = 64;  off_set[0] = int'($urandom_range(255, 0));
    duty_set[1] = 256; off_set[1] = 0;
    duty_set[2] = 0;   off_set[2] = 0;
    ticks(3 * 256 + 10);
    chk("d64_duty_1", int'(duty_1), 64);
    chk("hi_duty_2", int'(duty_2), 255);
    chk("lo_duty_3", int'(duty_3), 0);
    wait_valid("period_a", n);
    wait_valid("period_b", n);
    chk("valid_period", n, 256);

    // Random duties held for random spans.
    repeat (6) begin
      for (int k = 0; k < 3; k++) begin
        duty_set[k] = int'($urandom_range(256, 0));
        off_set[k]  = int'($urandom_range(255, 0));
      end
      ticks(int'($urandom_range(600, 256)));
    end

    // Forward rotation to lock, then reverse step and jump.
    fwd_seq();
    set_pat(3'b100, 1'b0); ticks(520);
    set_pat(3'b101, 1'b0); ticks(520);
    set_pat(3'b001, 1'b0); ticks(520);
    chk("lk_sector_3", int'(sector), 3);
    chk("lk_lock", int'(seq_lock), 1);
    set_pat(3'b101, 1'b0); ticks(520);
    chk("rev_sector_2", int'(sector), 2);
    chk("rev_seq_fwd", int'(seq_fwd), 0);
    chk("rev_seq_lock", int'(seq_lock), 0);
    set_pat(3'b010, 1'b0); ticks(520);
    chk("jump_sector_5", int'(sector), 5);
    chk("jump_seq_lock", int'(seq_lock), 0);

    // Invalid pattern while locked, then reset in mid-window.
    fwd_seq();
    set_pat(3'b111, 1'b0); ticks(520);
    chk("inv_pat_sector", int'(sector), 7);
    chk("inv_pat_lock", int'(seq_lock), 0);
    n = 0;
    while (e % 256 != 100 && n < 300) begin
      tick();
      n++;
    end
    chk("mid_reach_100", e % 256, 100);
    pulse_rst();
    chk("mid_rst_duty_1", int'(duty_1), 0);
    chk("mid_rst_duty_2", int'(duty_2), 0);
    chk("mid_rst_duty_3", int'(duty_3), 0);
    chk("mid_rst_valid", int'(duty_valid), 0);
    chk("mid_rst_sector", int'(sector), 7);
    chk("mid_rst_seq_fwd", int'(seq_fwd), 1);
    chk("mid_rst_lock", int'(seq_lock), 0);
    wait_valid("rst_release", n);
    chk("rst_to_valid", n, 256);

    // Complement mismatch persistence.
`ifdef SPWM_DEMOD_INV_CHECK_EN
    ticks(10);
    chk("inv_idle", int'(inv_fault), 0);
    glitch = 3; ticks(10);
    chk("inv_3clk", int'(inv_fault), 0);
    glitch = 4; ticks(10);
    chk("inv_4clk", int'(inv_fault), 1);
    ticks(300);
    chk("inv_sticky", int'(inv_fault), 1);
    pulse_rst();
    chk("inv_rst_clear", int'(inv_fault), 0);
`else
    glitch = 4; ticks(10);
    chk("inv_off_4clk", int'(inv_fault), 0);
    glitch = 20; ticks(40);
    chk("inv_off_long", int'(inv_fault), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
